// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// streams, with burst grant lock, an inter-byte gap and a tx_done timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MAX_BURST      = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       err_timeout,
  output logic [2:0]                 state_dbg
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [IW-1:0] LAST_ID   = IW'(NUM_REQ - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tout_cnt;

  logic [7:0]    req_bytes [NUM_REQ];
  logic          pick_found;
  logic [IW-1:0] pick_id;
  logic [IW:0]   scan_sum;
  logic          sel_valid;
  logic [7:0]    sel_data;
  logic          gap_done;
  logic          continue_ok;
  logic [IW-1:0] next_ptr;

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (IW+1)'(NUM_REQ);
      end
      if (!pick_found && req_valid[scan_sum[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = scan_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[8*i +: 8];
    end
  end

  assign sel_valid   = req_valid[grant_id];
  assign sel_data    = req_bytes[grant_id];
  assign gap_done    = (GAP_CYCLES == 0) || (gap_cnt == GAP_LAST);
  assign continue_ok = enable && sel_valid && (burst_cnt < BURST_MAX);
  assign next_ptr    = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  // Handshake: in ACCEPT the owner sees req_ready for exactly one cycle; a
  // byte transfers when req_valid and req_ready are both high on that edge,
  // and a low req_valid there hands the grant back without sending anything.
  assign req_ready   = (state == S_ACCEPT) ? (NUM_REQ'(1) << grant_id) : '0;
  assign tx_start    = (state == S_START) && !tx_busy;
  assign err_timeout = (state == S_WAIT) && !tx_done && (tout_cnt == TO_LAST);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      grant_id     <= '0;
      grant_active <= 1'b0;
      rr_ptr       <= '0;
      burst_cnt    <= '0;
      gap_cnt      <= '0;
      tout_cnt     <= '0;
      tx_data      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && pick_found) begin
            grant_id     <= pick_id;
            grant_active <= 1'b1;
            burst_cnt    <= '0;
            state        <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (sel_valid) begin
            tx_data   <= sel_data;
            burst_cnt <= burst_cnt + BW'(1);
            state     <= S_START;
          end else begin
            grant_active <= 1'b0;
            rr_ptr       <= next_ptr;
            state        <= S_IDLE;
          end
        end
        S_START: begin
          if (!tx_busy) begin
            tout_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end else if (tout_cnt == TO_LAST) begin
            grant_active <= 1'b0;
            rr_ptr       <= next_ptr;
            state        <= S_IDLE;
          end else begin
            tout_cnt <= tout_cnt + TW'(1);
          end
        end
        S_GAP: begin
          if (gap_done) begin
            if (continue_ok) begin
              state <= S_ACCEPT;
            end else begin
              grant_active <= 1'b0;
              rr_ptr       <= next_ptr;
              state        <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte-stream requesters.
- Arbitrates round-robin, with grant lock for bursts of up to MAX_BURST bytes.
- Sequences the transmitter through start/busy/done and enforces an inter-byte gap.
- Sits between client logic and the UART TX engine; the existing uart_if bench drives it at 50 MHz / 115200 baud.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 4: max consecutive bytes per grant before forced rotation, >=1.
- GAP_CYCLES, 16: idle clk cycles after each tx_done before the next byte is accepted, 0 allowed.
- TIMEOUT_CYCLES, 10000: max clk cycles in WAIT for tx_done before abort.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  arbitration enable
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot accept strobe
- tx_start  out  1  one-cycle start pulse to UART TX
- tx_data  out  8  byte to send, stable from tx_start until tx_done
- tx_busy  in  1  UART TX busy
- tx_done  in  1  one-cycle frame-complete pulse
- grant_id  out  $clog2(NUM_REQ)  current or last owner
- grant_active  out  1  a requester holds the grant
- err_timeout  out  1  one-cycle pulse on tx_done timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - All outputs 0: req_ready, tx_start, tx_data, grant_id, grant_active, err_timeout.
  - rr_ptr=0, burst_cnt=0, gap and timeout counters 0.
  - Reset mid-transfer abandons the byte immediately.
- States: IDLE, ACCEPT, START, WAIT, GAP.
- IDLE:
  - If enable and |req_valid: pick the first asserted index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register it into grant_id, set grant_active=1, burst_cnt=0, go ACCEPT.
  - Otherwise stay in IDLE.
- ACCEPT:
  - req_ready[grant_id]=1 for exactly this cycle, all other ready bits 0.
  - If req_valid[grant_id]=1: latch the byte into tx_data, burst_cnt++, go START.
  - If req_valid[grant_id]=0: release the grant, go IDLE.
- START:
  - If tx_busy=0: tx_start=1 for one cycle, clear timeout counter, go WAIT.
  - If tx_busy=1: hold in START, tx_start=0.
- WAIT:
  - On tx_done: go GAP.
  - Timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 without tx_done: err_timeout=1 for one cycle, release the grant, go IDLE.
  - tx_done outside WAIT is ignored.
- GAP:
  - Count GAP_CYCLES cycles. If GAP_CYCLES=0, the decision is made in the first GAP cycle.
  - At the end, continue the burst (go ACCEPT, same grant_id) only if enable=1, req_valid[grant_id]=1 and burst_cnt<MAX_BURST.
  - Otherwise release the grant.
- Release: grant_active=0, rr_ptr=(grant_id+1) mod NUM_REQ, go IDLE. grant_id holds its last value.
- Latency:
  - Requester valid in IDLE -> req_ready 1 cycle later (ACCEPT) -> tx_start on the next cycle if tx_busy=0.
  - Minimum byte-to-byte spacing inside a burst: tx_done + GAP_CYCLES + 2 cycles.
- enable:
  - Deasserting enable never aborts an in-flight byte; it only blocks new grants and burst continuation.
  - A requester that deasserts valid mid-burst loses the grant at its next ACCEPT; no byte is dropped or duplicated.
- Each accepted byte yields exactly one tx_start. tx_data changes only in ACCEPT.
- Simultaneous valid from all requesters: strict rotation, no starvation. Worst-case wait is (NUM_REQ-1)*MAX_BURST bytes.

Test Plan:
- NUM_REQ=4, GAP_CYCLES=4: req 0 alone sends 0xA5 -> req_ready[0] 1 cycle after valid, tx_start 1 cycle later with tx_data=0xA5. Serial line shows 0xA5; grant_active drops after the gap; rr_ptr=1.
- MAX_BURST=2: all four requesters valid continuously, bytes 0x10+i -> TX order 0x10,0x10,0x11,0x11,0x12,0x12,0x13,0x13, then 0x10 again.
- Req 2 valid for one byte only while burst allowed -> single 0x22 sent; grant released at the next ACCEPT; req 3 granted next.
- tx_busy held high 50 cycles after ACCEPT -> tx_start withheld until tx_busy=0, then exactly one pulse; tx_data stable throughout.
- TIMEOUT_CYCLES=100, tx_done never pulses -> err_timeout pulses at cycle 100 of WAIT; grant released; next requester served normally.
- rst_n pulled low during WAIT -> all outputs 0 asynchronously. After release, req 3 and req 0 both valid -> req 0 granted first.
